sr_ff_driver: RTL

Initiator-side sequencer for an SR flip-flop. It accepts write requests over a valid/ready handshake and converts each request into a legal S/R excitation pulse; S=R=1 is never driven. It then checks the flip-flop's q/qb feedback against the expected state and reports done or error. It sits between control logic and any `sr_flipflop` instance, replacing hand-driven `{s,r}` stimulus.

---
 rtl/sr_ff_driver.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sr_ff_driver.sv
// Request sequencer for an SR flip-flop: turns set/reset/toggle/hold requests into
// a legal S or R pulse, then checks q/qb feedback and reports done/err.
module sr_ff_driver #(
  parameter int PULSE_W = 1,
  parameter int TIMEOUT = 4,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  input  logic       q,
  input  logic       qb,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       q_exp
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tgt_q, tgt_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          qexp_q, qexp_d;
  logic          req_tgt;
  logic          match;

  always_comb begin
    case (req_op)
      2'b01:   req_tgt = 1'b0;
      2'b10:   req_tgt = 1'b1;
      2'b11:   req_tgt = ~qexp_q;
      default: req_tgt = qexp_q;
    endcase
  end

  // A stuck or shorted flip-flop (q==qb) can never satisfy this.
  assign match = (q == tgt_q) && (qb == ~tgt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    qexp_d  = qexp_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d = req_tgt;
          cnt_d = '0;
          if (req_tgt != qexp_q) begin
            state_d = DRIVE;
            s_d     = req_tgt;
            r_d     = ~req_tgt;
          end else begin
            state_d = WAIT;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          s_d   = s_q;
          r_d   = r_q;
        end
      end
      WAIT: begin
        if (match) begin
          state_d = RESP;
          done_d  = 1'b1;
          qexp_d  = tgt_q;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Give up and resynchronise to whatever the flip-flop actually holds.
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          qexp_d  = q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      qexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      qexp_q  <= qexp_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign q_exp     = qexp_q;

endmodule
